// File: rtl/bcd_countdown_2d_pkg.sv
// bcd_countdown_2d_pkg: shared FSM states, BCD limit and active-low 7-segment patterns
package bcd_countdown_2d_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [0:6] SEG_0 = 7'b0000001;
  localparam logic [0:6] SEG_1 = 7'b1001111;
  localparam logic [0:6] SEG_2 = 7'b0010010;
  localparam logic [0:6] SEG_3 = 7'b0000110;
  localparam logic [0:6] SEG_4 = 7'b1001100;
  localparam logic [0:6] SEG_5 = 7'b0100100;
  localparam logic [0:6] SEG_6 = 7'b0100000;
  localparam logic [0:6] SEG_7 = 7'b0001111;
  localparam logic [0:6] SEG_8 = 7'b0000000;
  localparam logic [0:6] SEG_9 = 7'b0000100;
  function automatic logic [0:6] seg7(input logic [3:0] d);
    unique case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      default: return SEG_9;
    endcase
  endfunction
  function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
    return n > BCD_MAX ? BCD_MAX : n;
  endfunction
endpackage

// File: rtl/bcd_countdown_2d_tick_gen.sv
// tick_gen: divides clk down to a one-cycle tick every CLK_HZ/TICK_HZ enabled cycles
module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int TC = CLK_HZ / TICK_HZ - 1;
  localparam int W  = TC > 0 ? $clog2(TC + 1) : 1;
  localparam logic [W-1:0] TC_W = W'(TC);
  logic [W-1:0] cnt_q;
  assign tick = en && cnt_q == TC_W;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en) cnt_q <= tick ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/bcd_countdown_2d.sv
// bcd_countdown_2d: two-digit BCD countdown timer with load, start/pause and done flag
module bcd_countdown_2d
  import bcd_countdown_2d_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic       CLOCK_50,
  input  logic [2:0] KEY,
  input  logic [7:0] SW,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [1:0] LEDG
);
  logic rst_n;
  logic [2:0] st_sh_q, ld_sh_q;
  logic start_p_q, load_p_q;
  state_e state_q, state_d;
  logic [3:0] tens_q, tens_d, units_q, units_d;
  logic tick, en, clr, zero;
  assign rst_n = KEY[0];
  // two synchroniser stages plus one history stage; pulse registered on the falling edge
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      st_sh_q   <= '1;
      ld_sh_q   <= '1;
      start_p_q <= 1'b0;
      load_p_q  <= 1'b0;
    end else begin
      st_sh_q   <= {st_sh_q[1:0], KEY[1]};
      ld_sh_q   <= {ld_sh_q[1:0], KEY[2]};
      start_p_q <= st_sh_q[2] & ~st_sh_q[1];
      load_p_q  <= ld_sh_q[2] & ~ld_sh_q[1];
    end
  assign zero = tens_q == 4'd0 && units_q == 4'd0;
  // a pause request freezes the divider in the same cycle, so no tick slips through
  assign en = state_q == RUN && !start_p_q;
  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk(CLOCK_50), .rst_n(rst_n), .en(en), .clr(clr), .tick(tick)
  );
  always_comb begin
    state_d = state_q;
    tens_d  = tens_q;
    units_d = units_q;
    clr     = 1'b0;
    if (load_p_q && state_q != RUN) begin
      tens_d  = bcd_clamp(SW[7:4]);
      units_d = bcd_clamp(SW[3:0]);
      state_d = IDLE;
    end else if (start_p_q) begin
      unique case (state_q)
        IDLE: begin
          clr     = 1'b1;
          state_d = zero ? DONE : RUN;
        end
        RUN: state_d = PAUSE;
        PAUSE: begin
          clr     = 1'b1;
          state_d = RUN;
        end
        default: state_d = state_q;
      endcase
    end else if (tick && !zero) begin
      units_d = units_q != 4'd0 ? units_q - 4'd1 : BCD_MAX;
      tens_d  = units_q != 4'd0 ? tens_q : tens_q - 4'd1;
      state_d = tens_q == 4'd0 && units_q == 4'd1 ? DONE : RUN;
    end
  end
  always_ff @(posedge CLOCK_50 or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      state_q <= state_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  assign HEX0 = seg7(units_q);
  assign HEX1 = seg7(tens_q);
  assign LEDG = {state_q == RUN, state_q == DONE};
endmodule
